// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
//
// Purpose: RV32 funct3 size/sign codes, internal access-size codes, the FSM
// state enum and the funct3 decode helpers used by load_store_unit.
// Ports: none (package).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Unsigned codes exist only for loads; any undefined code is a full word.
  function automatic logic [1:0] f3_size(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_W:    sz = SZ_W;
      F3_BU:   sz = we ? SZ_W : SZ_B;
      F3_HU:   sz = we ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword lane merge and extract for the load/store unit
//
// Purpose: combinational lane logic. Store side replaces the addressed lanes
// of a memory word; load side extracts the addressed lanes and extends them.
// Ports:
//   i_size     access size code (SZ_B/SZ_H/SZ_W)
//   i_unsigned zero-extend instead of sign-extend on loads
//   i_off      byte offset within the word (addr[1:0])
//   i_word     memory word being merged into / extracted from
//   i_wdata    right-aligned store data
//   o_merged   full word to write back
//   o_loaded   extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_loaded
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    if (i_size == SZ_B)
      o_loaded = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
    else if (i_size == SZ_H)
      o_loaded = {{16{w_half[15] & ~i_unsigned}}, w_half};
    else
      o_loaded = i_word;
  end

  always_comb begin
    o_merged = i_word;
    if (i_size == SZ_B) begin
      case (i_off)
        2'd0:    o_merged[7:0]   = i_wdata[7:0];
        2'd1:    o_merged[15:8]  = i_wdata[7:0];
        2'd2:    o_merged[23:16] = i_wdata[7:0];
        default: o_merged[31:24] = i_wdata[7:0];
      endcase
    end else if (i_size == SZ_H) begin
      if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
      else          o_merged[15:0]  = i_wdata[15:0];
    end else begin
      o_merged = i_wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit in front of a word-wide memory
//
// Purpose: accepts one access at a time, performs read / read-modify-write /
// write on a word memory and returns an extended load result.
// Build option: MISALIGN_TRAP_EN - misaligned halfword/word accesses complete
// immediately with resp_err=1 instead of being forced to alignment.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             access handshake
//   req_we, req_funct3              store flag and RV32 size/sign code
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err  one-cycle completion with result
//   mem_read, mem_write             memory strobes (never both)
//   mem_addr, mem_wdata, mem_rdata  word-aligned memory address and data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_trap;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr_al;
  logic [31:0]       w_align_word;
  logic [31:0]       w_merged;
  logic [31:0]       w_loaded;

  assign w_size   = f3_size(req_we, req_funct3);
  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Low address bits are forced to the access alignment before latching.
  always_comb begin
    w_addr_al = req_addr;
    if (w_size == SZ_H)      w_addr_al[0]   = 1'b0;
    else if (w_size == SZ_W) w_addr_al[1:0] = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;

  assign w_trap = ((w_size == SZ_H) && req_addr[0]) ||
                  ((w_size == SZ_W) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_trap;
  end

  assign resp_err = r_err;
`else
  assign w_trap   = 1'b0;
  assign resp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. Sub-word stores need the old word, so they read first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_trap)                         w_next = ST_RESP;
          else if (req_we && w_size == SZ_W)  w_next = ST_WRITE;
          else                                w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latch and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= w_size;
        r_uns   <= f3_unsigned(req_funct3);
        r_addr  <= w_addr_al;
        r_wdata <= req_wdata;
        r_rdata <= '0;
      end
      if (r_state == ST_READ) begin
        r_word <= mem_rdata;
        if (!r_we) r_rdata <= w_loaded;
      end
    end
  end

  // Loads extract straight from the live read data; stores merge into the
  // captured word.
  assign w_align_word = (r_state == ST_WRITE) ? r_word : mem_rdata;

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_off      (r_addr[1:0]),
    .i_word     (w_align_word),
    .i_wdata    (r_wdata),
    .o_merged   (w_merged),
    .o_loaded   (w_loaded)
  );

  // Output logic
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    mem_read   = (r_state == ST_READ);
    mem_write  = (r_state == ST_WRITE);
    resp_valid = (r_state == ST_RESP);
    mem_wdata  = (r_state == ST_WRITE) ? w_merged : 32'h0;
    mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    resp_rdata = r_rdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic        err;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  assign mem_rdata = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) env_mem[mem_addr[9:2]] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Reference behaviour from the RV32 rules: size, alignment, lane shift/mask.
  function automatic exp_t ref_access(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int unsigned sz, ea, sh, mask, w, v;
    bit          sgn, trap;
    e.rdata = 0; e.wdata = 0; e.maddr = 0; e.err = 0;
    e.lat = 0; e.acc = 0; e.nrd = 0; e.nwr = 0;
    sgn = 0;
    trap = 0;
    if (!we) begin
      case (f3)
        3'd0: begin sz = 1; sgn = 1; end
        3'd1: begin sz = 2; sgn = 1; end
        3'd4: sz = 1;
        3'd5: sz = 2;
        default: sz = 4;
      endcase
    end else begin
      case (f3)
        3'd0: sz = 1;
        3'd1: sz = 2;
        default: sz = 4;
      endcase
    end
`ifdef MISALIGN_TRAP_EN
    if (addr % sz != 0) trap = 1;
`endif
    if (trap) begin
      e.err = 1;
      e.lat = 1;
      return e;
    end
    ea      = addr - addr % sz;
    e.maddr = ea - ea % 4;
    sh      = 8 * (ea % 4);
    mask    = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    w       = ref_mem[ea / 4];
    if (!we) begin
      v = (w >> sh) & mask;
      if (sgn && v >= (mask + 1) / 2) v = v | ~mask;
      e.rdata = v;
      e.lat   = 2;
      e.nrd   = 1;
    end else begin
      w = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[ea / 4] = w;
      e.wdata = w;
      e.lat   = (sz == 4) ? 2 : 3;
      e.nrd   = (sz == 4) ? 0 : 1;
      e.nwr   = 1;
    end
    return e;
  endfunction

  // Monitor: checks strobes against the head expectation, pops on resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_read || mem_write) begin
        chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
        if (sb.size() != 0) chk("mem_addr", mem_addr, sb[0].maddr);
      end
      if (mem_read) n_rd++;
      if (mem_write) begin
        n_wr++;
        if (sb.size() == 0) fail_line("stray_mem_write");
        else chk("mem_wdata", mem_wdata, sb[0].wdata);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          fail_line("stray_resp_valid");
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", cyc - e.acc, e.lat);
          chk("mem_read_count", n_rd, e.nrd);
          chk("mem_write_count", n_wr, e.nwr);
          last_rdata = resp_rdata;
          last_err   = resp_err;
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_line("req_ready_timeout");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    e = ref_access(we, f3, addr, wdata);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_line("resp_timeout");
      sb.delete();
    end
  endtask

  initial begin
    int a1, a2, acc, nbad;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset_resp_err", {31'b0, resp_err}, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_mem_read", {31'b0, mem_read}, 32'h0);
    chk("reset_mem_write", {31'b0, mem_write}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);

    // Sign/zero extension on a known word
    do_req(1'b1, 3'b010, 32'h100, 32'h8000_80F0, acc);
    do_req(1'b0, 3'b000, 32'h100, 32'h0, acc);
    drain();
    chk("lb_0x100", last_rdata, 32'hFFFF_FFF0);
    do_req(1'b0, 3'b100, 32'h101, 32'h0, acc);
    drain();
    chk("lbu_0x101", last_rdata, 32'h0000_0080);

    // Byte store into a known word, then read it back
    do_req(1'b1, 3'b010, 32'h200, 32'h1122_3344, acc);
    do_req(1'b1, 3'b000, 32'h202, 32'h0000_00AA, acc);
    do_req(1'b0, 3'b010, 32'h200, 32'h0, acc);
    drain();
    chk("sb_0x202_word", last_rdata, 32'h11AA_3344);

    // Back-to-back store then load
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, a1);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, a2);
    drain();
    chk("lw_after_sw", last_rdata, 32'hDEAD_BEEF);
    chk("b2b_accept_gap", a2 - a1, 3);

`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h102, 32'h0, acc);
    drain();
    chk("trap_lw_err", {31'b0, last_err}, 32'h1);
`endif

    // Reset during the READ of an SH
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h300; req_wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("sh_in_read", {31'b0, mem_read}, 32'h1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_rd = 0;
    n_wr = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
    chk("post_rst_mem_addr", mem_addr, 32'h0);
    repeat (5) @(negedge clk);
    chk("post_rst_word", env_mem[8'hC0], ref_mem[8'hC0]);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 1023)), $urandom, acc);
    end
    drain();

    nbad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) nbad++;
    chk("final_memory_words_bad", nbad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of the memory interface.
REQ-002 SHALL have port clk, input, 1, meaning the single clock, with all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning the pipeline presents an access.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit can accept an access.
REQ-006 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, meaning the RV32 size/sign code: LB/LH/LW/LBU/LHU and SB/SH/SW.
REQ-008 SHALL have port req_addr, input, ADDR_W, meaning the byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning the store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, meaning the extended load result (0 for stores).
REQ-012 SHALL have port resp_err, output, 1, meaning the access was misaligned; it is valid with resp_valid.
REQ-013 SHALL have port mem_read, output, 1, meaning the read strobe to the word memory.
REQ-014 SHALL have port mem_write, output, 1, meaning the write strobe; memory writes on the rising edge.
REQ-015 SHALL have port mem_addr, output, ADDR_W, meaning the word-aligned byte address, with bits [1:0] = 0.
REQ-016 SHALL have port mem_wdata, output, 32, meaning the full-word write data.
REQ-017 SHALL have port mem_rdata, input, 32, meaning the combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and RESP.
REQ-019 SHALL assert req_ready only in IDLE, and SHALL accept a request on req_valid && req_ready, latching all req_* fields.
REQ-020 SHALL transition from IDLE to READ on accept of a load, an SB or an SH.
REQ-021 SHALL transition from IDLE to WRITE on accept of an SW.
REQ-022 SHALL, in READ, assert mem_read, capture mem_rdata into a word register, and go to WRITE for a store or to RESP for a load.
REQ-023 SHALL, in WRITE, assert mem_write with mem_wdata equal to the captured word with the addressed byte or halfword lanes replaced (SB/SH), or equal to req_wdata (SW), then go to RESP.
REQ-024 SHALL, in RESP, pulse resp_valid for one cycle and return to IDLE.
REQ-025 SHALL select byte lane addr[1:0] for LB/LBU and halfword addr[1] for LH/LHU, sign-extending LB/LH and zero-extending LBU/LHU.
REQ-026 SHALL give the following accept-to-resp_valid latency: loads 2 cycles, SW 2 cycles, SB/SH 3 cycles.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle, and SHALL hold both low outside READ and WRITE.
REQ-028 SHALL ignore a req_valid arriving while not in IDLE; the request is not accepted, and the requester holds it.
REQ-029 SHALL accept a new request in the IDLE cycle immediately following RESP, giving back-to-back operation.
REQ-030 SHALL treat an undefined funct3 as LW or SW.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE and clear resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata and the capture register to 0.
REQ-032 SHALL, on reset mid-operation (READ or WRITE), abandon the operation with no further mem_write and no resp_valid.

Configuration
REQ-033 SHALL, with MISALIGN_TRAP_EN defined, go directly from IDLE to RESP with resp_err=1, resp_rdata=0 and no memory strobe for a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access.
REQ-034 SHALL, without MISALIGN_TRAP_EN, tie resp_err to 0 and force the low address bits to alignment (halfword addr[0]=0, word addr[1:0]=0) before the access.

Structure
REQ-035 SHALL place the funct3 encoding constants and the FSM state enum typedef in the shared package lsu_pkg.
REQ-036 SHALL place the combinational lane merge (store) and lane extract/extend (load) in the single sub-module lsu_align.

Verification
REQ-037 SHALL cover: memory word 0x100 = 0x8000_80F0, then LB at 0x100 -> resp_rdata 0xFFFF_FFF0 at accept+2.
REQ-038 SHALL cover: memory word 0x100 = 0x8000_80F0, then LBU at 0x101 -> resp_rdata 0x0000_0080.
REQ-039 SHALL cover: memory word 0x200 = 0x1122_3344, then SB 0xAA at 0x202 -> mem_wdata 0x11AA_3344 in WRITE, resp_valid at accept+3, one mem_read and one mem_write.
REQ-040 SHALL cover: SW 0xDEAD_BEEF at 0x10 then LW at 0x10 back-to-back -> 0xDEAD_BEEF, with the second accept in the cycle after the first RESP.
REQ-041 SHALL cover: with MISALIGN_TRAP_EN, LW at 0x102 -> resp_err=1 at accept+1, and mem_read and mem_write never asserted.
REQ-042 SHALL cover: rst asserted during the READ of an SH to 0x300 -> no mem_write, no resp_valid, req_ready=1 the cycle after reset.
